agc_rupt_ctrl: RTL and testbench
================================

# agc_rupt_ctrl

Interrupt (RUPT) controller for the AGC core. Latches up to ten interrupt sources, resolves them by fixed priority, and at a legal instruction boundary hands the control-pulse sequencer a vector address. Blocks nested interrupts until RESUME and honours INHINT/RELINT, extracode and accumulator-overflow lockouts. It sits beside the control-pulse FSM and feeds the Z/memory-address path with the vector.

## Interface
- NUM_SRC, 10, number of interrupt sources; bit 0 is highest priority (T6RUPT … HANDRUPT).
- VEC_BASE, 12'o4000, fixed-memory base; vector for source n = VEC_BASE + 4*(n+1).
- LOCK_CYCLES, 4096, ISR-duration limit for the RUPT LOCK alarm (used only with AGC_RUPT_LOCK_EN).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- rupt_req  in  NUM_SRC  interrupt requests, level or single-cycle pulse.
- inst_boundary  in  1  sequencer is at end of instruction, next fetch not started.
- extracode  in  1  extracode flag is set; blocks grant.
- a_overflow  in  1  regA[15] != regA[14]; blocks grant.
- inhint  in  1  one-cycle pulse, set inhibit.
- relint  in  1  one-cycle pulse, clear inhibit.
- resume  in  1  one-cycle pulse, RESUME executed.
- rupt_ack  in  1  sequencer has taken the vector.
- rupt_go  out  1  interrupt request to sequencer.
- rupt_vec  out  12  vector address, valid while rupt_go.
- rupt_id  out  4  granted source index.
- in_isr  out  1  interrupt service in progress.
- pending  out  NUM_SRC  latched pending requests.
- rupt_lock  out  1  sticky RUPT LOCK alarm.

## Operation
- Pending latch: pending[i] <= pending[i] | rupt_req[i] every cycle. It clears only for the granted bit on rupt_ack. If rupt_req[id] is high in the ack cycle, set wins and the bit stays pending.
- Inhibit flag: inhint sets it and relint clears it. If both arrive in the same cycle, inhint wins.
- States:
  - IDLE: go to REQ when (pending != 0) & !inhibit & inst_boundary & !extracode & !a_overflow. On that edge, latch rupt_id = lowest set pending index and compute rupt_vec.
  - REQ: rupt_go = 1. rupt_id and rupt_vec are frozen, even if a higher-priority request arrives. On rupt_ack, go to ISR and clear pending[rupt_id]. resume is ignored in this state.
  - ISR: in_isr = 1. No new grant is made. On resume, return to IDLE. inhint/relint are still tracked.
- resume in IDLE is ignored.
- rupt_ack outside REQ is ignored.
- Reset (asynchronous, any state, including mid-handshake) drives:
  - state=IDLE, pending=0, inhibit=0;
  - rupt_go=0, rupt_vec=0, rupt_id=0, in_isr=0, rupt_lock=0.

## Timing
- rupt_req at edge n → pending visible after edge n.
- Earliest rupt_go is after edge n+1, provided inst_boundary and the gating conditions are high in cycle n+1.
- rupt_go stays high until the edge that samples rupt_ack, then drops. in_isr rises on that same edge.
- Gating inputs are sampled only in IDLE; changes during REQ have no effect.
- in_isr falls on the edge sampling resume. The next grant needs a fresh inst_boundary, so the earliest is one cycle later.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- AGC_RUPT_LOCK_EN defined:
  - A cycle counter is cleared on ISR entry and increments every cycle in ISR.
  - On reaching LOCK_CYCLES it sets rupt_lock, which is sticky until reset.
  - The counter saturates and does not wrap.
- Undefined: no counter is built and rupt_lock is tied to 0.

## Structure
- Shared package agc_pkg holds:
  - the state enum (IDLE, REQ, ISR);
  - source index constants (T6RUPT=0 … HANDRUPT=9);
  - VEC_BASE and vector spacing.
- Sub-module agc_rupt_prio: combinational lowest-index priority encoder giving a 4-bit index and an any-valid flag.

## Test plan
- Reset mid-REQ: assert reset while rupt_go=1 → all outputs 0 immediately, pending=0.
- Single source: rupt_req[3] pulse, boundary high → rupt_go with rupt_id=3, rupt_vec=12'o4020. Ack → in_isr=1, pending[3]=0. Resume → IDLE.
- Priority and freeze:
  - Stimulus: req[5] and req[2] together, boundary → id=2.
  - Raise req[0] during REQ → id stays 2.
  - After ack and resume with boundary → id=0, then id=5.
- Lockouts: pending[4] set with inhibit=1, extracode=1 or a_overflow=1 at boundary → no rupt_go. Relint and all lockouts clear → grant on next boundary.
- Nesting and simultaneity:
  - req[1] during ISR → stays pending, no rupt_go until after resume.
  - inhint and relint in the same cycle → inhibit=1.
  - req[id] high in the ack cycle → pending[id] remains 1.
- With AGC_RUPT_LOCK_EN and LOCK_CYCLES=16: no resume for 16 ISR cycles → rupt_lock=1, stays 1 after resume. Without the macro → rupt_lock always 0.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared AGC interrupt-controller definitions: controller states, RUPT source indices, vector layout.
// Used by agc_rupt_ctrl (optional AGC_RUPT_LOCK_EN feature lives in the top) and agc_rupt_prio.
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ISR  = 2'd2
    } rupt_state_e;

    localparam int unsigned NUM_RUPT_SRC = 10;

    // Source indices, highest priority first
    localparam int unsigned T6RUPT    = 0;
    localparam int unsigned T5RUPT    = 1;
    localparam int unsigned T3RUPT    = 2;
    localparam int unsigned T4RUPT    = 3;
    localparam int unsigned KEYRUPT1  = 4;
    localparam int unsigned KEYRUPT2  = 5;
    localparam int unsigned UPRUPT    = 6;
    localparam int unsigned DOWNRUPT  = 7;
    localparam int unsigned RADARRUPT = 8;
    localparam int unsigned HANDRUPT  = 9;

    localparam logic [11:0] RUPT_VEC_BASE = 12'o4000;
    localparam int unsigned RUPT_VEC_STEP = 4;

    // Vector for source n sits one step past the base: base + step*(n+1)
    function automatic logic [11:0] rupt_vector(input logic [11:0] base, input logic [3:0] idx);
        return base + 12'(RUPT_VEC_STEP) * ({8'd0, idx} + 12'd1);
    endfunction

endpackage

// File: rtl/agc_rupt_prio.sv
// Combinational lowest-index-wins priority encoder for pending RUPT sources.
module agc_rupt_prio
    import agc_pkg::*;
#(
    parameter int unsigned N = NUM_RUPT_SRC
) (
    input  logic [N-1:0] req_i,
    output logic [3:0]   idx_o,
    output logic         valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!valid_o && req_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/agc_rupt_ctrl.sv
// AGC interrupt controller: pending latch, inhibit/lockout gating, IDLE->REQ->ISR handshake.
// Define AGC_RUPT_LOCK_EN to build the RUPT LOCK ISR-duration alarm; otherwise rupt_lock is tied low.
module agc_rupt_ctrl
    import agc_pkg::*;
#(
    parameter int unsigned NUM_SRC     = NUM_RUPT_SRC,
    parameter logic [11:0] VEC_BASE    = RUPT_VEC_BASE,
    parameter int unsigned LOCK_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] rupt_req,
    input  logic               inst_boundary,
    input  logic               extracode,
    input  logic               a_overflow,
    input  logic               inhint,
    input  logic               relint,
    input  logic               resume,
    input  logic               rupt_ack,
    output logic               rupt_go,
    output logic [11:0]        rupt_vec,
    output logic [3:0]         rupt_id,
    output logic               in_isr,
    output logic [NUM_SRC-1:0] pending,
    output logic               rupt_lock
);

    rupt_state_e        state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d, ack_clr;
    logic               inhibit_q, inhibit_d;
    logic [3:0]         id_q, id_d;
    logic [11:0]        vec_q, vec_d;
    logic               go_q, go_d;
    logic               isr_q, isr_d;
    logic [3:0]         prio_idx;
    logic               prio_valid;
    logic               grant;
    logic               take_ack;

    agc_rupt_prio #(.N(NUM_SRC)) u_prio (
        .req_i   (pending_q),
        .idx_o   (prio_idx),
        .valid_o (prio_valid)
    );

    // Gating inputs only matter while idle; REQ holds its grant regardless
    assign grant    = (state_q == IDLE) && prio_valid && !inhibit_q && inst_boundary
                      && !extracode && !a_overflow;
    assign take_ack = (state_q == REQ) && rupt_ack;

    // A request arriving in the ack cycle re-sets the bit being cleared
    always_comb begin
        ack_clr   = take_ack ? (NUM_SRC'(1) << id_q) : '0;
        pending_d = (pending_q & ~ack_clr) | rupt_req;
        inhibit_d = inhibit_q;
        if (inhint) begin
            inhibit_d = 1'b1;
        end else if (relint) begin
            inhibit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant)    state_d = REQ;
            REQ:     if (rupt_ack) state_d = ISR;
            ISR:     if (resume)   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight off flops
    always_comb begin
        go_d  = (state_d == REQ);
        isr_d = (state_d == ISR);
        id_d  = id_q;
        vec_d = vec_q;
        if (grant) begin
            id_d  = prio_idx;
            vec_d = rupt_vector(VEC_BASE, prio_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            inhibit_q <= 1'b0;
            id_q      <= '0;
            vec_q     <= '0;
            go_q      <= 1'b0;
            isr_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            inhibit_q <= inhibit_d;
            id_q      <= id_d;
            vec_q     <= vec_d;
            go_q      <= go_d;
            isr_q     <= isr_d;
        end
    end

    assign rupt_go  = go_q;
    assign rupt_vec = vec_q;
    assign rupt_id  = id_q;
    assign in_isr   = isr_q;
    assign pending  = pending_q;

`ifdef AGC_RUPT_LOCK_EN
    localparam int unsigned       CNT_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;

    // Counter restarts on ISR entry and saturates at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (take_ack) begin
            cnt_d = '0;
        end else if (state_q == ISR && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        lock_d = lock_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign rupt_lock = lock_q;
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^LOCK_CYCLES;
    assign rupt_lock       = 1'b0;
`endif

endmodule

// File: tb/tb_agc_rupt_ctrl.sv
// Directed scoreboard bench for agc_rupt_ctrl; expected grants are queued, a monitor checks each rupt_go.
module tb_agc_rupt_ctrl;
    import agc_pkg::*;

    localparam int unsigned NSRC = 10;

`ifdef AGC_RUPT_LOCK_EN
    localparam logic EXP_LOCK = 1'b1;
`else
    localparam logic EXP_LOCK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] rupt_req;
    logic            inst_boundary, extracode, a_overflow;
    logic            inhint, relint, resume, rupt_ack;
    logic            rupt_go;
    logic [11:0]     rupt_vec;
    logic [3:0]      rupt_id;
    logic            in_isr;
    logic [NSRC-1:0] pending;
    logic            rupt_lock;

    agc_rupt_ctrl #(
        .NUM_SRC     (NSRC),
        .VEC_BASE    (12'o4000),
        .LOCK_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rupt_req      (rupt_req),
        .inst_boundary (inst_boundary),
        .extracode     (extracode),
        .a_overflow    (a_overflow),
        .inhint        (inhint),
        .relint        (relint),
        .resume        (resume),
        .rupt_ack      (rupt_ack),
        .rupt_go       (rupt_go),
        .rupt_vec      (rupt_vec),
        .rupt_id       (rupt_id),
        .in_isr        (in_isr),
        .pending       (pending),
        .rupt_lock     (rupt_lock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  id;
        logic [11:0] vec;
    } grant_t;

    grant_t      exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        go_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input logic [3:0] id, input logic [11:0] vec);
        grant_t g;
        g.id  = id;
        g.vec = vec;
        exp_q.push_back(g);
    endtask

    // Monitor: every rising rupt_go must match the oldest queued grant
    always @(negedge clk) begin
        grant_t g;
        if (rupt_go && !go_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got id=%0d vec=%o, expected no grant", rupt_id, rupt_vec);
            end else begin
                g = exp_q.pop_front();
                check("grant_id", 32'(rupt_id), 32'(g.id));
                check("grant_vec", 32'(rupt_vec), 32'(g.vec));
            end
        end
        go_prev = rupt_go;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rupt_req = '0;
        inst_boundary = 1'b0;
        extracode = 1'b0;
        a_overflow = 1'b0;
        inhint = 1'b0;
        relint = 1'b0;
        resume = 1'b0;
        rupt_ack = 1'b0;
        repeat (2) tick();
        check("reset_go", 32'(rupt_go), 0);
        check("reset_vec", 32'(rupt_vec), 0);
        check("reset_id", 32'(rupt_id), 0);
        check("reset_isr", 32'(in_isr), 0);
        check("reset_pending", 32'(pending), 0);
        check("reset_lock", 32'(rupt_lock), 0);
        reset = 1'b0;
        tick();

        // Single source T4RUPT
        rupt_req = 10'h008; inst_boundary = 1'b1;
        tick();
        rupt_req = '0;
        check("single_pending", 32'(pending), 32'h008);
        check("single_go_not_yet", 32'(rupt_go), 0);
        expect_grant(4'd3, 12'o4020);
        tick();
        check("single_go", 32'(rupt_go), 1);
        rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0;
        check("single_ack_go", 32'(rupt_go), 0);
        check("single_ack_isr", 32'(in_isr), 1);
        check("single_ack_pending", 32'(pending), 0);
        tick();
        check("single_isr_hold", 32'(in_isr), 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("single_resume_isr", 32'(in_isr), 0);
        inst_boundary = 1'b0;
        tick();

        // Priority and freeze
        rupt_req = 10'h024;
        tick();
        rupt_req = '0;
        check("prio_pending", 32'(pending), 32'h024);
        expect_grant(4'd2, 12'o4014);
        inst_boundary = 1'b1;
        tick();
        check("prio_go", 32'(rupt_go), 1);
        inst_boundary = 1'b0; rupt_req = 10'h001;
        tick();
        rupt_req = '0;
        check("freeze_id", 32'(rupt_id), 2);
        check("freeze_vec", 32'(rupt_vec), 32'(12'o4014));
        check("freeze_pending", 32'(pending), 32'h025);
        rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0;
        check("prio_ack_pending", 32'(pending), 32'h021);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        expect_grant(4'd0, 12'o4004);
        inst_boundary = 1'b1;
        tick();
        check("prio0_go", 32'(rupt_go), 1);
        rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        expect_grant(4'd5, 12'o4030);
        tick();
        check("prio5_go", 32'(rupt_go), 1);
        rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0; resume = 1'b1; inst_boundary = 1'b0;
        tick();
        resume = 1'b0;
        check("prio_done_pending", 32'(pending), 0);

        // Lockouts: inhibit, extracode, overflow
        rupt_req = 10'h010; inhint = 1'b1;
        tick();
        rupt_req = '0; inhint = 1'b0; inst_boundary = 1'b1;
        repeat (2) tick();
        check("inhibit_block", 32'(rupt_go), 0);
        check("inhibit_pending", 32'(pending), 32'h010);
        extracode = 1'b1; relint = 1'b1;
        tick();
        relint = 1'b0;
        tick();
        check("extracode_block", 32'(rupt_go), 0);
        extracode = 1'b0; a_overflow = 1'b1;
        repeat (2) tick();
        check("overflow_block", 32'(rupt_go), 0);
        a_overflow = 1'b0;
        expect_grant(4'd4, 12'o4024);
        tick();
        check("lockout_release_go", 32'(rupt_go), 1);

        // Request for the granted source in the ack cycle stays pending
        rupt_ack = 1'b1; rupt_req = 10'h010;
        tick();
        rupt_ack = 1'b0; rupt_req = '0;
        check("ack_set_wins", 32'(pending), 32'h010);
        check("ack_set_isr", 32'(in_isr), 1);

        // Nesting blocked; inhint+relint together leaves inhibit set
        rupt_req = 10'h002;
        tick();
        rupt_req = '0;
        repeat (3) tick();
        check("nest_no_go", 32'(rupt_go), 0);
        check("nest_pending", 32'(pending), 32'h012);
        inhint = 1'b1; relint = 1'b1;
        tick();
        inhint = 1'b0; relint = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        check("nest_resume_isr", 32'(in_isr), 0);
        repeat (2) tick();
        check("both_inhibit_block", 32'(rupt_go), 0);
        relint = 1'b1;
        tick();
        relint = 1'b0;
        expect_grant(4'd1, 12'o4010);
        tick();
        check("nest_go", 32'(rupt_go), 1);
        rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        expect_grant(4'd4, 12'o4024);
        tick();
        check("relatch_go", 32'(rupt_go), 1);

        // Long ISR: RUPT LOCK alarm
        inst_boundary = 1'b0; rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0;
        repeat (5) tick();
        check("lock_early", 32'(rupt_lock), 0);
        repeat (15) tick();
        check("lock_alarm", 32'(rupt_lock), 32'(EXP_LOCK));
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("lock_sticky", 32'(rupt_lock), 32'(EXP_LOCK));
        check("lock_resume_isr", 32'(in_isr), 0);

        // rupt_ack outside REQ has no effect
        rupt_req = 10'h040;
        tick();
        rupt_req = '0; rupt_ack = 1'b1;
        tick();
        rupt_ack = 1'b0;
        check("ack_idle_ignored", 32'(pending), 32'h040);

        // Asynchronous reset mid-REQ
        expect_grant(4'd6, 12'o4034);
        inst_boundary = 1'b1;
        tick();
        check("mid_req_go", 32'(rupt_go), 1);
        rupt_req = 10'h080;
        tick();
        rupt_req = '0;
        check("mid_req_pending", 32'(pending), 32'h0c0);
        #2;
        reset = 1'b1;
        #1;
        check("areset_go", 32'(rupt_go), 0);
        check("areset_vec", 32'(rupt_vec), 0);
        check("areset_id", 32'(rupt_id), 0);
        check("areset_pending", 32'(pending), 0);
        check("areset_lock", 32'(rupt_lock), 0);
        tick();
        reset = 1'b0; inst_boundary = 1'b0;
        repeat (2) tick();
        check("post_reset_go", 32'(rupt_go), 0);
        check("leftover_expected", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
